// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the stopwatch display (ss.hh).
// Digits are latched once per frame; outputs are registered one cycle behind idx/snap.
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    // A one-cycle dwell still needs a 1-bit counter that simply sits at zero.
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [3:0]    snap_r [0:3];
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          tc_s;
    logic          frame_start_s;
    logic [CW-1:0] cnt_nxt_s;
    logic [1:0]    idx_nxt_s;
    logic [3:0]    digit_s;
    logic [3:0]    an_nxt_s;
    logic [6:0]    seg_nxt_s;
    logic          dp_nxt_s;

    // Refresh counter and digit ring advance.
    always_comb begin
        tc_s          = (cnt_r == CNT_LAST);
        frame_start_s = (cnt_r == CNT_ZERO) && (idx_r == 2'd0);
        cnt_nxt_s     = cnt_r;
        idx_nxt_s     = idx_r;
        if (tc_s) begin
            cnt_nxt_s = CNT_ZERO;
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            idx_nxt_s = idx_r;
        end
    end

    // Next output values from the current digit slot and snapshot.
    always_comb begin
        digit_s   = snap_r[idx_r];
        an_nxt_s  = 4'b1111;
        seg_nxt_s = bcd_to_seg(digit_s);
        dp_nxt_s  = 1'b1;
        case (idx_r)
            2'd0:    an_nxt_s = 4'b1110;
            2'd1:    an_nxt_s = 4'b1101;
            2'd2:    an_nxt_s = 4'b1011;
            2'd3: begin
                // Tens-of-seconds leading zero stays dark.
                if (digit_s == 4'd0) begin
                    an_nxt_s = 4'b1111;
                end else begin
                    an_nxt_s = 4'b0111;
                end
            end
            default: an_nxt_s = 4'b1111;
        endcase
        if (idx_r == 2'd2) begin
            dp_nxt_s = 1'b0;
        end else begin
            dp_nxt_s = 1'b1;
        end
    end

    // Scan state, frame snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= CNT_ZERO;
            idx_r     <= 2'd0;
            snap_r[0] <= 4'd0;
            snap_r[1] <= 4'd0;
            snap_r[2] <= 4'd0;
            snap_r[3] <= 4'd0;
            an_r      <= 4'b1111;
            seg_r     <= 7'h7F;
            dp_r      <= 1'b1;
        end else begin
            cnt_r <= cnt_nxt_s;
            idx_r <= idx_nxt_s;
            if (frame_start_s) begin
                snap_r[0] <= d0;
                snap_r[1] <= d1;
                snap_r[2] <= d2;
                snap_r[3] <= d3;
            end
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed scoreboard bench for sseg_scan_driver at REFRESH_DIV=4, plus a random
// sweep checking anode exclusivity and dwell length.
module tb_sseg_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d0, d1, d2, d3;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    sseg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .reset(reset),
        .d0   (d0),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_no = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_no, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic p, input int n);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = p;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic set_digits(input logic [3:0] v3, input logic [3:0] v2,
                              input logic [3:0] v1, input logic [3:0] v0);
        d3 = v3;
        d2 = v2;
        d1 = v1;
        d0 = v0;
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                chk("an",  {12'd0, an},  {12'd0, e.an});
                chk("seg", {9'd0, seg},  {9'd0, e.seg});
                chk("dp",  {15'd0, dp},  {15'd0, e.dp});
            end
        end
    endtask

    // Canonical post-reset frame for inputs 1,2,3,4.
    task automatic push_first_frame();
        push(4'b1110, 7'h40, 1'b1, 1);
        push(4'b1110, 7'h19, 1'b1, 3);
        push(4'b1101, 7'h30, 1'b1, 4);
        push(4'b1011, 7'h24, 1'b0, 4);
        push(4'b0111, 7'h79, 1'b1, 4);
    endtask

    initial begin
        logic [3:0] prev_an;
        int         run;
        bit         first_run;

        // 1: reset and first frame
        reset = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        push(4'b1111, 7'h7F, 1'b1, 3);
        step(3);
        reset = 1'b0;
        push_first_frame();
        step(16);

        // 2: leading-zero blank
        set_digits(4'd0, 4'd5, 4'd9, 4'd9);
        push(4'b1110, 7'h19, 1'b1, 1);
        push(4'b1110, 7'h10, 1'b1, 3);
        push(4'b1101, 7'h10, 1'b1, 4);
        push(4'b1011, 7'h12, 1'b0, 4);
        push(4'b1111, 7'h40, 1'b1, 4);
        step(16);

        // 3: inputs change during idx=1 without tearing the frame
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        push(4'b1110, 7'h10, 1'b1, 1);
        push(4'b1110, 7'h40, 1'b1, 3);
        push(4'b1101, 7'h40, 1'b1, 4);
        step(5);
        set_digits(4'd8, 4'd8, 4'd8, 4'd8);
        push(4'b1011, 7'h40, 1'b0, 4);
        push(4'b1111, 7'h40, 1'b1, 4);
        push(4'b1110, 7'h40, 1'b1, 1);
        push(4'b1110, 7'h00, 1'b1, 3);
        push(4'b1101, 7'h00, 1'b1, 4);
        push(4'b1011, 7'h00, 1'b0, 4);
        push(4'b0111, 7'h00, 1'b1, 4);
        step(27);

        // 4: illegal BCD renders as a dash
        set_digits(4'd7, 4'hB, 4'd7, 4'd7);
        push(4'b1110, 7'h00, 1'b1, 1);
        push(4'b1110, 7'h78, 1'b1, 3);
        push(4'b1101, 7'h78, 1'b1, 4);
        push(4'b1011, 7'h3F, 1'b0, 4);
        push(4'b0111, 7'h78, 1'b1, 4);
        step(16);

        // 5: reset at idx=2, cnt=1, then a clean restart
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        push(4'b1110, 7'h78, 1'b1, 1);
        push(4'b1110, 7'h19, 1'b1, 3);
        push(4'b1101, 7'h30, 1'b1, 4);
        push(4'b1011, 7'h24, 1'b0, 1);
        step(9);
        reset = 1'b1;
        push(4'b1111, 7'h7F, 1'b1, 1);
        step(1);
        reset = 1'b0;
        push_first_frame();
        step(16);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        // 6: random sweep, 10 frames: exclusivity and 4-cycle dwell
        prev_an   = an;
        run       = 0;
        first_run = 1'b1;
        for (int i = 0; i < 160; i++) begin
            set_digits(4'($urandom_range(15)), 4'($urandom_range(15)),
                       4'($urandom_range(15)), 4'($urandom_range(15)));
            @(posedge clk);
            #1;
            edge_no++;
            chk("an_onehot0", 16'($countones(~an) <= 1), 16'd1);
            if (an == prev_an) begin
                run++;
            end else begin
                if (!first_run) chk("dwell", 16'(run), 16'd4);
                first_run = 1'b0;
                run       = 1;
                prev_an   = an;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
